// File: rtl/encoder_4to2_seq.sv
// encoder_4to2_seq: captures 4 request lines into a pending set and presents
// them one at a time as a 2-bit code over a valid/ready handshake.
// Optional feature macro: ENC_ROUND_ROBIN_EN selects round-robin arbitration
// (search upward from a rotating pointer). When it is undefined, the lowest
// pending index wins and no pointer register exists.
module encoder_4to2_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] req_in,
  input  logic       out_ready,
  output logic [1:0] code_out,
  output logic       out_valid,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       handshake;
  logic [3:0] clear_mask;
  logic [1:0] sel_idx;

`ifdef ENC_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Pick the first pending line at or above the pointer, wrapping 3 -> 0.
  always_comb begin
    logic [1:0] cand;
    sel_idx = ptr_q;
    // Scan from the farthest offset down so the nearest set line wins last.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (pending_q[cand]) sel_idx = cand;
    end
  end
`else
  // Fixed priority: the lowest pending index wins.
  always_comb begin
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 2'(i);
    end
  end
`endif

  // Next-state logic: pending capture, handshake clear, and the FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
`ifdef ENC_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif

    handshake  = (state_q == PRESENT) && out_ready;
    clear_mask = handshake ? (4'b0001 << code_q) : 4'b0000;
    // A line re-requested on its own accept cycle stays pending: set wins.
    pending_d  = (pending_q & ~clear_mask) | (enable ? req_in : 4'b0000);

    case (state_q)
      IDLE: begin
        // Arbitrate only on the registered set, never on live req_in.
        if (|pending_q) begin
          code_d  = sel_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Hold code and valid until the consumer takes them.
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
`ifdef ENC_ROUND_ROBIN_EN
          ptr_d   = code_q + 2'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that overrides any handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      code_q    <= 2'b00;
      valid_q   <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q     <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign code_out  = code_q;
  assign out_valid = valid_q;
  assign pending   = pending_q;
  assign busy      = (|pending_q) | valid_q;

endmodule
